cam_cmd_master: RTL and testbench

//  Initiator side of the CAM port set: drives read/write/search requests into cam and returns results.

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_cmd_fifo.sv | 43 ++++
 rtl/cam_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_cam_cmd_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: CAM op encoding, default widths, command record and FSM states
// shared by the CAM command master and its command FIFO.
package cam_pkg;
    localparam int CAM_IDX_W  = 5;
    localparam int CAM_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_SEARCH  = 2'd2,
        OP_ILLEGAL = 2'd3
    } cam_op_e;

    typedef struct packed {
        cam_op_e               op;
        logic [CAM_IDX_W-1:0]  index;
        logic [CAM_DATA_W-1:0] data;
    } cam_cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} cam_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/cam_cmd_fifo.sv
// cam_cmd_fifo: DEPTH-entry command FIFO; pointers carry one extra wrap bit
// so full/empty come from comparing the MSBs.
module cam_cmd_fifo
    import cam_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cam_cmd_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/cam_cmd_master.sv
// cam_cmd_master: queues read/write/search commands, issues one CAM access at a time
// and returns results in order. Optional CAM_MASTER_STATS_EN adds saturating response counters.
module cam_cmd_master
    import cam_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_LAT   = 1,
    parameter int IDX_W     = CAM_IDX_W,
    parameter int DATA_W    = CAM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [IDX_W-1:0]  cmd_index_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [1:0]        rsp_op_o,
    output logic              rsp_hit_o,
    output logic              rsp_err_o,
    output logic [IDX_W-1:0]  rsp_index_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              read_enable_o,
    output logic [IDX_W-1:0]  read_index_o,
    output logic              write_enable_o,
    output logic [IDX_W-1:0]  write_index_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              search_enable_o,
    output logic [DATA_W-1:0] search_data_o,
    input  logic              read_valid_i,
    input  logic [DATA_W-1:0] read_value_i,
    input  logic              search_valid_i,
    input  logic [IDX_W-1:0]  search_index_i,
`ifdef CAM_MASTER_STATS_EN
    output logic [15:0]       stat_hits_o,
    output logic [15:0]       stat_miss_o,
    output logic [15:0]       stat_err_o,
`endif
    output logic              busy_o
);
    localparam int CW = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;

    typedef struct packed {
        cam_op_e           op;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t              cmd_in, head;
    logic              full, empty, push, pop;
    cam_state_e        state;
    cam_op_e           op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic [CW-1:0]     cnt;

    assign cmd_in      = {cmd_op_i, cmd_index_i, cmd_data_i};
    assign cmd_ready_o = rst_i && !full;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = !empty && (state == ST_IDLE || (state == ST_RESP && rsp_ready_i));
    assign busy_o      = !empty || state != ST_IDLE;

    assign read_index_o  = idx_q;
    assign write_index_o = idx_q;
    assign write_data_o  = data_q;
    assign search_data_o = data_q;

    cam_cmd_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_t)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= ST_IDLE;
            op_q            <= OP_READ;
            idx_q           <= '0;
            data_q          <= '0;
            cnt             <= '0;
            read_enable_o   <= 1'b0;
            write_enable_o  <= 1'b0;
            search_enable_o <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_op_o        <= '0;
            rsp_hit_o       <= 1'b0;
            rsp_err_o       <= 1'b0;
            rsp_index_o     <= '0;
            rsp_data_o      <= '0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ISSUE: begin
                    read_enable_o   <= 1'b0;
                    write_enable_o  <= 1'b0;
                    search_enable_o <= 1'b0;
                    if (op_q == OP_ILLEGAL) begin
                        state       <= ST_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_op_o    <= op_q;
                        rsp_hit_o   <= 1'b0;
                        rsp_err_o   <= 1'b1;
                        rsp_index_o <= idx_q;
                        rsp_data_o  <= data_q;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= CW'(RSP_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state       <= ST_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_op_o    <= op_q;
                        rsp_err_o   <= 1'b0;
                        rsp_hit_o   <= (op_q == OP_READ) ? read_valid_i :
                                       (op_q == OP_SEARCH) ? search_valid_i : 1'b1;
                        rsp_index_o <= (op_q == OP_SEARCH) ? search_index_i : idx_q;
                        rsp_data_o  <= (op_q == OP_READ) ? read_value_i : data_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
            endcase
            // Popping the head launches the next access, from IDLE or straight out of RESP.
            if (pop) begin
                state           <= ST_ISSUE;
                op_q            <= head.op;
                idx_q           <= head.index;
                data_q          <= head.data;
                read_enable_o   <= head.op == OP_READ;
                write_enable_o  <= head.op == OP_WRITE;
                search_enable_o <= head.op == OP_SEARCH;
            end
        end
    end

`ifdef CAM_MASTER_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_hits_o <= '0;
            stat_miss_o <= '0;
            stat_err_o  <= '0;
        end else if (rsp_fire) begin
            if (rsp_err_o) stat_err_o <= sat_inc(stat_err_o);
            else if (rsp_op_o == OP_SEARCH && rsp_hit_o) stat_hits_o <= sat_inc(stat_hits_o);
            else if (rsp_op_o == OP_SEARCH) stat_miss_o <= sat_inc(stat_miss_o);
        end
    end
`endif
endmodule

// File: tb/tb_cam_cmd_master.sv
// tb_cam_cmd_master: directed commands against a behavioural 1-cycle CAM; expected
// responses are queued at issue time and checked by an independent response monitor.
module tb_cam_cmd_master;
    typedef struct packed {
        logic [1:0]  op;
        logic        hit;
        logic        err;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [4:0]  cmd_index_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [1:0]  rsp_op_o;
    logic        rsp_hit_o, rsp_err_o;
    logic [4:0]  rsp_index_o;
    logic [31:0] rsp_data_o;
    logic        read_enable_o, write_enable_o, search_enable_o;
    logic [4:0]  read_index_o, write_index_o;
    logic [31:0] write_data_o, search_data_o;
    logic        read_valid_i = 1'b0, search_valid_i = 1'b0;
    logic [31:0] read_value_i = '0;
    logic [4:0]  search_index_i = '0;
    logic        busy_o;
`ifdef CAM_MASTER_STATS_EN
    logic [15:0] stat_hits_o, stat_miss_o, stat_err_o;
`endif

    cam_cmd_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_index_i(cmd_index_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_op_o(rsp_op_o), .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
        .rsp_index_o(rsp_index_o), .rsp_data_o(rsp_data_o),
        .read_enable_o(read_enable_o), .read_index_o(read_index_o),
        .write_enable_o(write_enable_o), .write_index_o(write_index_o), .write_data_o(write_data_o),
        .search_enable_o(search_enable_o), .search_data_o(search_data_o),
        .read_valid_i(read_valid_i), .read_value_i(read_value_i),
        .search_valid_i(search_valid_i), .search_index_i(search_index_i),
`ifdef CAM_MASTER_STATS_EN
        .stat_hits_o(stat_hits_o), .stat_miss_o(stat_miss_o), .stat_err_o(stat_err_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_rise = 0;
    int rcnt = 0, wcnt = 0, scnt = 0;
    logic [4:0]  w_idx;
    logic [31:0] w_data, s_data;
    exp_t sb[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural CAM with one cycle of latency from the enable edge.
    logic [31:0] cmem [32];
    logic        cval [32];
    initial for (int i = 0; i < 32; i++) begin cmem[i] = '0; cval[i] = 1'b0; end

    function automatic logic [5:0] cam_find(input logic [31:0] key);
        for (int i = 0; i < 32; i++) if (cval[i] && cmem[i] == key) return {1'b1, 5'(i)};
        return 6'd0;
    endfunction

    always @(posedge clk_i) begin
        if (write_enable_o) begin
            cmem[write_index_o] <= write_data_o;
            cval[write_index_o] <= 1'b1;
        end
        if (read_enable_o) begin
            read_valid_i <= cval[read_index_o];
            read_value_i <= cmem[read_index_o];
        end
        if (search_enable_o) {search_valid_i, search_index_i} <= cam_find(search_data_o);
    end

    // Enable pulse bookkeeping and one-hot check.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (read_enable_o) rcnt <= rcnt + 1;
            if (write_enable_o) begin
                wcnt   <= wcnt + 1;
                w_idx  <= write_index_o;
                w_data <= write_data_o;
            end
            if (search_enable_o) begin
                scnt   <= scnt + 1;
                s_data <= search_data_o;
            end
            if (read_enable_o || write_enable_o || search_enable_o) begin
                checks++;
                if ($countones({read_enable_o, write_enable_o, search_enable_o}) > 1) begin
                    errors++;
                    $display("FAIL enable_overlap: got r=%0b w=%0b s=%0b, need at most one",
                             read_enable_o, write_enable_o, search_enable_o);
                end
            end
        end
    end

    // Response monitor: scoreboard pop on handshake, payload stability while stalled.
    exp_t got, held;
    logic stall = 1'b0, pv = 1'b0;
    assign got = {rsp_op_o, rsp_hit_o, rsp_err_o, rsp_index_o, rsp_data_o};

    always @(negedge clk_i) begin
        if (!rst_i) begin
            stall <= 1'b0;
            pv    <= 1'b0;
        end else begin
            if (rsp_valid_o && !pv) last_rise <= cyc;
            pv <= rsp_valid_o;
            if (rsp_valid_o && stall) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL rsp_stable: got %h, need held %h", got, held);
                end
            end
            stall <= rsp_valid_o && !rsp_ready_i;
            held  <= got;
            if (rsp_valid_o && rsp_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got op=%0d hit=%0b err=%0b idx=%0d data=%h, need none",
                             got.op, got.hit, got.err, got.idx, got.data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rsp_payload: got op=%0d hit=%0b err=%0b idx=%0d data=%h, need op=%0d hit=%0b err=%0b idx=%0d data=%h",
                                 got.op, got.hit, got.err, got.idx, got.data,
                                 e.op, e.hit, e.err, e.idx, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    task automatic expect_rsp(input logic [1:0] op, input logic hit, input logic err,
                              input logic [4:0] idx, input logic [31:0] data);
        sb.push_back({op, hit, err, idx, data});
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
        int n = 0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_index_i = idx;
        cmd_data_i  = data;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: got ready=0, need ready=1");
            cmd_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            accept_cyc  = cyc;
            cmd_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, need 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {7'd0, cmd_ready_o, rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_err_o, rsp_index_o,
                rsp_data_o, read_enable_o, read_index_o, write_enable_o, write_index_o,
                write_data_o, search_enable_o, search_data_o, busy_o};
    endfunction

    int b_r, b_w, b_s;

    initial begin
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = '0;
        cmd_index_i = '0;
        cmd_data_i  = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", all_outs(), '0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_reset_busy", 128'(busy_o), 128'(0));
        check("post_reset_ready", 128'(cmd_ready_o), 128'(1));

        // T1: reset while the write sits in WAIT drops everything in the same cycle.
        send(2'd1, 5'd7, 32'h11111111);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("midwait_reset_outputs", all_outs(), '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midwait_release_busy", 128'(busy_o), 128'(0));
        check("midwait_release_ready", 128'(cmd_ready_o), 128'(1));

        // T2: write pulse shape and N+3 response latency.
        b_w = wcnt;
        expect_rsp(2'd1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        send(2'd1, 5'd3, 32'hDEADBEEF);
        drain();
        check("write_pulses", 128'(wcnt - b_w), 128'(1));
        check("write_index", 128'(w_idx), 128'(3));
        check("write_data", 128'(w_data), 128'hDEADBEEF);
        check("write_rsp_latency", 128'(last_rise - accept_cyc), 128'(3));

        // T3: search hit then miss.
        b_s = scnt;
        expect_rsp(2'd2, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        send(2'd2, 5'd0, 32'hDEADBEEF);
        drain();
        check("search_pulses", 128'(scnt - b_s), 128'(1));
        check("search_key", 128'(s_data), 128'hDEADBEEF);
        expect_rsp(2'd2, 1'b0, 1'b0, 5'd0, 32'h0BADF00D);
        send(2'd2, 5'd0, 32'h0BADF00D);
        drain();

        // T4: read back, then an illegal op with no CAM activity.
        expect_rsp(2'd0, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        send(2'd0, 5'd3, 32'h0);
        drain();
        b_r = rcnt; b_w = wcnt; b_s = scnt;
        expect_rsp(2'd3, 1'b0, 1'b1, 5'd9, 32'h00000055);
        send(2'd3, 5'd9, 32'h00000055);
        drain();
        check("illegal_no_enables", 128'((rcnt - b_r) + (wcnt - b_w) + (scnt - b_s)), 128'(0));

        // T5: stalled responses fill the FIFO; release drains in order.
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        expect_rsp(2'd1, 1'b1, 1'b0, 5'd10, 32'hA0A0A0A0);
        send(2'd1, 5'd10, 32'hA0A0A0A0);
        expect_rsp(2'd1, 1'b1, 1'b0, 5'd11, 32'hA1A1A1A1);
        send(2'd1, 5'd11, 32'hA1A1A1A1);
        expect_rsp(2'd0, 1'b1, 1'b0, 5'd10, 32'hA0A0A0A0);
        send(2'd0, 5'd10, 32'h0);
        expect_rsp(2'd2, 1'b1, 1'b0, 5'd11, 32'hA1A1A1A1);
        send(2'd2, 5'd0, 32'hA1A1A1A1);
        expect_rsp(2'd0, 1'b0, 1'b0, 5'd12, 32'h0);
        send(2'd0, 5'd12, 32'h0);
        repeat (3) @(negedge clk_i);
        check("full_ready_low", 128'(cmd_ready_o), 128'(0));
        check("full_busy", 128'(busy_o), 128'(1));
        check("stalled_valid", 128'(rsp_valid_o), 128'(1));
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        drain();
        check("ready_after_drain", 128'(cmd_ready_o), 128'(1));

`ifdef CAM_MASTER_STATS_EN
        // T6: searches since the last reset: two hits, one miss; one illegal op.
        check("stat_hits", 128'(stat_hits_o), 128'(2));
        check("stat_miss", 128'(stat_miss_o), 128'(1));
        check("stat_err", 128'(stat_err_o), 128'(1));
`endif

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
